// File: rtl/rambus_openram_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rambus_openram_responder
// Brief    : Wishbone responder that turns single bus cycles into OpenRAM
//            single-port accesses (one RAM strobe per bus transaction).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rambus_openram_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,

    input  logic                rambus_wb_stb_i,
    input  logic                rambus_wb_cyc_i,
    input  logic                rambus_wb_we_i,
    input  logic [DATA_W/8-1:0] rambus_wb_sel_i,
    input  logic [DATA_W-1:0]   rambus_wb_dat_i,
    input  logic [ADDR_W-1:0]   rambus_wb_adr_i,
    output logic                rambus_wb_ack_o,
    output logic [DATA_W-1:0]   rambus_wb_dat_o,

    output logic                ram_clk0,
    output logic                ram_csb0,
    output logic                ram_web0,
    output logic [DATA_W/8-1:0] ram_wmask0,
    output logic [ADDR_W-1:0]   ram_addr0,
    output logic [DATA_W-1:0]   ram_din0,
    input  logic [DATA_W-1:0]   ram_dout0
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   adr_q,   adr_d;
    logic [DATA_W-1:0]   dat_q,   dat_d;
    logic [SEL_W-1:0]    sel_q,   sel_d;
    logic                we_q,    we_d;
    logic                abort_q, abort_d;
    logic [DATA_W-1:0]   rdat_q,  rdat_d;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            abort_q <= abort_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        abort_d = abort_q;
        rdat_d  = rdat_q;
        case (state_q)
            S_IDLE: begin
                if (rambus_wb_cyc_i && rambus_wb_stb_i) begin
                    adr_d   = rambus_wb_adr_i;
                    dat_d   = rambus_wb_dat_i;
                    sel_d   = rambus_wb_sel_i;
                    we_d    = rambus_wb_we_i;
                    abort_d = 1'b0;
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                // A dropped cycle lets the RAM access finish but remembers to withhold ack.
                abort_d = abort_q | ~rambus_wb_cyc_i;
                state_d = we_q ? S_ACK : S_CAPTURE;
            end
            S_CAPTURE: begin
                abort_d = abort_q | ~rambus_wb_cyc_i;
                rdat_d  = ram_dout0;
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic w_mem;
    assign w_mem = (state_q == S_MEM);

    assign ram_clk0   = wb_clk_i;
    assign ram_csb0   = ~w_mem;
    assign ram_web0   = ~(w_mem & we_q);
    assign ram_wmask0 = (w_mem && we_q) ? sel_q : '0;
    assign ram_addr0  = adr_q;
    assign ram_din0   = dat_q;

    assign rambus_wb_ack_o = (state_q == S_ACK) & rambus_wb_cyc_i & ~abort_q;
    assign rambus_wb_dat_o = rdat_q;

endmodule
`default_nettype wire

// File: tb/tb_rambus_openram_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_rambus_openram_responder
// Brief    : Directed self-checking bench with a behavioural OpenRAM model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rambus_openram_responder;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b1;
    logic        rambus_wb_stb_i = 1'b0;
    logic        rambus_wb_cyc_i = 1'b0;
    logic        rambus_wb_we_i = 1'b0;
    logic [3:0]  rambus_wb_sel_i = '0;
    logic [31:0] rambus_wb_dat_i = '0;
    logic [7:0]  rambus_wb_adr_i = '0;
    logic        rambus_wb_ack_o;
    logic [31:0] rambus_wb_dat_o;
    logic        ram_clk0;
    logic        ram_csb0;
    logic        ram_web0;
    logic [3:0]  ram_wmask0;
    logic [7:0]  ram_addr0;
    logic [31:0] ram_din0;
    logic [31:0] ram_dout0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt  = 0;

    rambus_openram_responder #(.ADDR_W(8), .DATA_W(32)) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_ni       (wb_rst_ni),
        .rambus_wb_stb_i (rambus_wb_stb_i),
        .rambus_wb_cyc_i (rambus_wb_cyc_i),
        .rambus_wb_we_i  (rambus_wb_we_i),
        .rambus_wb_sel_i (rambus_wb_sel_i),
        .rambus_wb_dat_i (rambus_wb_dat_i),
        .rambus_wb_adr_i (rambus_wb_adr_i),
        .rambus_wb_ack_o (rambus_wb_ack_o),
        .rambus_wb_dat_o (rambus_wb_dat_o),
        .ram_clk0        (ram_clk0),
        .ram_csb0        (ram_csb0),
        .ram_web0        (ram_web0),
        .ram_wmask0      (ram_wmask0),
        .ram_addr0       (ram_addr0),
        .ram_din0        (ram_din0),
        .ram_dout0       (ram_dout0)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // OpenRAM-style single port: samples on the clock edge, read data one cycle later.
    logic [31:0] mem [256];
    logic [31:0] rd_q = '0;
    assign ram_dout0 = rd_q;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
    end

    always @(posedge ram_clk0) begin
        if (!ram_csb0) begin
            if (!ram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wmask0[b]) mem[ram_addr0][b*8 +: 8] <= ram_din0[b*8 +: 8];
            end else begin
                rd_q <= mem[ram_addr0];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
        cyc_cnt++;
    endtask

    // One complete bus transaction; returns with the bench in the cycle after ack.
    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp_dat_o,
                           output int ack_cyc);
        int  start;
        bit  got;
        rambus_wb_cyc_i = 1'b1;
        rambus_wb_stb_i = 1'b1;
        rambus_wb_we_i  = we;
        rambus_wb_adr_i = adr;
        rambus_wb_dat_i = dat;
        rambus_wb_sel_i = sel;
        start = cyc_cnt;
        tick();
        check("mem_csb0",   {31'd0, ram_csb0}, 32'd0);
        check("mem_web0",   {31'd0, ram_web0}, {31'd0, ~we});
        check("mem_wmask0", {28'd0, ram_wmask0}, we ? {28'd0, sel} : 32'd0);
        check("mem_addr0",  {24'd0, ram_addr0}, {24'd0, adr});
        if (we) check("mem_din0", ram_din0, dat);
        rambus_wb_stb_i = 1'b0;
        rambus_wb_we_i  = ~we;
        rambus_wb_adr_i = ~adr;
        rambus_wb_dat_i = ~dat;
        rambus_wb_sel_i = ~sel;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rambus_wb_ack_o) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        ack_cyc = cyc_cnt;
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check("ack_latency", ack_cyc - start, we ? 32'd2 : 32'd3);
            check("ack_dat_o", rambus_wb_dat_o, exp_dat_o);
            check("ack_csb0", {31'd0, ram_csb0}, 32'd1);
        end
        tick();
        check("ack_one_cycle", {31'd0, rambus_wb_ack_o}, 32'd0);
        rambus_wb_cyc_i = 1'b0;
    endtask

    initial begin
        int a0, a1, a2, ax;
        #1 wb_rst_ni = 1'b0;
        #2;
        check("rst_ack",   {31'd0, rambus_wb_ack_o}, 32'd0);
        check("rst_dat_o", rambus_wb_dat_o, 32'd0);
        check("rst_csb0",  {31'd0, ram_csb0}, 32'd1);
        check("rst_web0",  {31'd0, ram_web0}, 32'd1);
        check("rst_wmask", {28'd0, ram_wmask0}, 32'd0);
        check("rst_addr",  {24'd0, ram_addr0}, 32'd0);
        check("rst_din",   ram_din0, 32'd0);
        tick();
        tick();
        wb_rst_ni = 1'b1;

        // Single write/read, then back-to-back write, write, read.
        wb_xfer(1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 32'h0, a0);
        wb_xfer(1'b1, 8'hFF, 32'h12345678, 4'hF, 32'h0, a1);
        check("b2b_write_gap", a1 - a0, 32'd3);
        wb_xfer(1'b0, 8'hFF, 32'h0, 4'hF, 32'h12345678, a2);
        check("b2b_read_gap", a2 - a1, 32'd4);
        wb_xfer(1'b0, 8'h05, 32'h0, 4'h0, 32'hDEADBEEF, ax);

        // Byte-lane write, then a sel=0 write that must leave memory unchanged.
        wb_xfer(1'b1, 8'h05, 32'h00000011, 4'h1, 32'hDEADBEEF, ax);
        wb_xfer(1'b0, 8'h05, 32'h0, 4'hF, 32'hDEADBE11, ax);
        wb_xfer(1'b1, 8'h05, 32'hFFFFFFFF, 4'h0, 32'hDEADBE11, ax);
        wb_xfer(1'b0, 8'h05, 32'h0, 4'hF, 32'hDEADBE11, ax);

        // Read with cyc dropped in CAPTURE: data still captured, no ack.
        wb_xfer(1'b1, 8'h20, 32'hCAFEF00D, 4'hF, 32'hDEADBE11, ax);
        rambus_wb_cyc_i = 1'b1;
        rambus_wb_stb_i = 1'b1;
        rambus_wb_we_i  = 1'b0;
        rambus_wb_adr_i = 8'h20;
        tick();
        rambus_wb_stb_i = 1'b0;
        tick();
        rambus_wb_cyc_i = 1'b0;
        tick();
        check("drop_ack", {31'd0, rambus_wb_ack_o}, 32'd0);
        check("drop_dat_o", rambus_wb_dat_o, 32'hCAFEF00D);
        tick();
        check("drop_idle_csb0", {31'd0, ram_csb0}, 32'd1);
        check("drop_idle_ack", {31'd0, rambus_wb_ack_o}, 32'd0);

        // Reset pulsed during MEM of a write aborts it before the RAM samples.
        wb_xfer(1'b1, 8'h30, 32'h0BADF00D, 4'hF, 32'hCAFEF00D, ax);
        rambus_wb_cyc_i = 1'b1;
        rambus_wb_stb_i = 1'b1;
        rambus_wb_we_i  = 1'b1;
        rambus_wb_adr_i = 8'h30;
        rambus_wb_dat_i = 32'h55555555;
        rambus_wb_sel_i = 4'hF;
        tick();
        check("rstmem_csb0_before", {31'd0, ram_csb0}, 32'd0);
        rambus_wb_stb_i = 1'b0;
        #2 wb_rst_ni = 1'b0;
        #1;
        check("rstmem_csb0",  {31'd0, ram_csb0}, 32'd1);
        check("rstmem_web0",  {31'd0, ram_web0}, 32'd1);
        check("rstmem_wmask", {28'd0, ram_wmask0}, 32'd0);
        check("rstmem_addr",  {24'd0, ram_addr0}, 32'd0);
        check("rstmem_din",   ram_din0, 32'd0);
        check("rstmem_dat_o", rambus_wb_dat_o, 32'd0);
        check("rstmem_ack",   {31'd0, rambus_wb_ack_o}, 32'd0);
        tick();
        wb_rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstmem_no_ack", {31'd0, rambus_wb_ack_o}, 32'd0);
        end
        rambus_wb_cyc_i = 1'b0;
        wb_xfer(1'b0, 8'h30, 32'h0, 4'hF, 32'h0BADF00D, ax);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
